pixel_reorder_queue: RTL and testbench

//  Multi-channel reorder buffer between NUM_CH pixel engines and the combinator.

---
 rtl/pixel_reorder_queue.sv | 158 +++++++++++++++
 tb/tb_pixel_reorder_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reorder_queue.sv
// Multi-channel reorder buffer: per-engine circular FIFOs released in raster order.
// Optional DEDUP_EN drops pushes whose x repeats the channel's last accepted x.
module pixel_reorder_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int RGB_SIZE   = 24,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              in_valid,
  output logic [NUM_CH-1:0]              in_ready,
  input  logic [NUM_CH*RGB_SIZE-1:0]     in_colour,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_x,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_y,
  input  logic [DATA_WIDTH-1:0]          check_x,
  input  logic [DATA_WIDTH-1:0]          check_y,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RGB_SIZE-1:0]            out_colour,
  output logic [$clog2(NUM_CH):0]        out_ch,
  output logic [NUM_CH-1:0]              full,
  output logic                           empty
);

  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int ENT_W = 2 * DATA_WIDTH + RGB_SIZE;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [NUM_CH-1:0]                hit;
  logic [NUM_CH-1:0]                pop;
  logic [NUM_CH-1:0]                cnt_zero;
  logic [NUM_CH-1:0][RGB_SIZE-1:0]  head_col;
  logic                             any_hit;
  logic                             free;
  logic                             pop_en;
  logic [CH_W-1:0]                  sel;
  logic [RGB_SIZE-1:0]              sel_col;

  logic                             out_valid_q;
  logic [RGB_SIZE-1:0]              out_colour_q;
  logic [CH_W-1:0]                  out_ch_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ENT_W-1:0]      mem_q [DEPTH];
      logic [PTR_W-1:0]      wr_ptr_q;
      logic [PTR_W-1:0]      rd_ptr_q;
      logic [PTR_W:0]        cnt_q;
      logic [PTR_W:0]        cnt_d;
      logic [DATA_WIDTH-1:0] push_x;
      logic [DATA_WIDTH-1:0] head_x;
      logic [DATA_WIDTH-1:0] head_y;
      logic [ENT_W-1:0]      head;
      logic                  push_hs;
      logic                  push_wr;

      assign push_x        = in_x[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_ready[gi]  = (cnt_q != FULL_CNT);
      assign full[gi]      = (cnt_q == FULL_CNT);
      assign cnt_zero[gi]  = (cnt_q == '0);
      assign push_hs       = in_valid[gi] && in_ready[gi];

`ifdef DEDUP_EN
      logic [DATA_WIDTH-1:0] last_x_q;

      // A repeat is still handshaken so the engine moves on; it just isn't stored.
      assign push_wr = push_hs && (push_x != last_x_q);

      always_ff @(posedge clk) begin
        if (reset) begin
          last_x_q <= '1;
        end else if (push_hs) begin
          last_x_q <= push_x;
        end
      end
`else
      assign push_wr = push_hs;
`endif

      // Head is read asynchronously so the match can be evaluated in the same cycle.
      assign head          = mem_q[rd_ptr_q];
      assign head_x        = head[ENT_W-1 -: DATA_WIDTH];
      assign head_y        = head[RGB_SIZE +: DATA_WIDTH];
      assign head_col[gi]  = head[RGB_SIZE-1:0];
      assign hit[gi]       = !cnt_zero[gi] && (head_x == check_x) && (head_y == check_y);
      assign pop[gi]       = pop_en && (sel == CH_W'(gi));

      always_comb begin
        cnt_d = cnt_q;
        case ({push_wr, pop[gi]})
          2'b10:   cnt_d = cnt_q + CNT_ONE;
          2'b01:   cnt_d = cnt_q - CNT_ONE;
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_d;
          if (push_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
          if (pop[gi]) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (push_wr) begin
          mem_q[wr_ptr_q] <= {push_x, in_y[gi*DATA_WIDTH +: DATA_WIDTH],
                              in_colour[gi*RGB_SIZE +: RGB_SIZE]};
        end
      end
    end
  endgenerate

  // Lowest-numbered matching channel wins; other hits wait for a later cycle.
  always_comb begin
    sel     = '0;
    sel_col = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        sel     = CH_W'(c);
        sel_col = head_col[c];
      end
    end
  end

  assign any_hit = |hit;
  assign free    = !out_valid_q || out_ready;
  assign pop_en  = free && any_hit;
  assign empty   = &cnt_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_colour_q <= '0;
      out_ch_q     <= '0;
    end else if (pop_en) begin
      out_valid_q  <= 1'b1;
      out_colour_q <= sel_col;
      out_ch_q     <= sel;
    end else if (free) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_colour = out_colour_q;
  assign out_ch     = out_ch_q;

endmodule

// File: tb/tb_pixel_reorder_queue.sv
// Directed bench for pixel_reorder_queue (NUM_CH=2, DEPTH=4) with an output scoreboard.
// Expectations for the repeated-x case follow the DEDUP_EN macro.
module tb_pixel_reorder_queue;

  localparam int DW  = 32;
  localparam int RGB = 24;
  localparam int DEP = 4;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*RGB-1:0] in_colour;
  logic [NCH*DW-1:0] in_x;
  logic [NCH*DW-1:0] in_y;
  logic [DW-1:0]     check_x;
  logic [DW-1:0]     check_y;
  logic              out_valid;
  logic              out_ready;
  logic [RGB-1:0]    out_colour;
  logic [1:0]        out_ch;
  logic [NCH-1:0]    full;
  logic              empty;

  int          checks = 0;
  int          errors = 0;
  logic [25:0] sb[$];
  logic [25:0] mon_exp;

  pixel_reorder_queue #(
    .DATA_WIDTH(DW), .RGB_SIZE(RGB), .DEPTH(DEP), .NUM_CH(NCH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_colour(in_colour),
    .in_x(in_x), .in_y(in_y), .check_x(check_x), .check_y(check_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_colour(out_colour),
    .out_ch(out_ch), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_px(input int ch, input logic [31:0] x, input logic [31:0] y,
                          input logic [23:0] c);
    in_x[ch*DW +: DW]       = x;
    in_y[ch*DW +: DW]       = y;
    in_colour[ch*RGB +: RGB] = c;
  endtask

  task automatic set_check(input logic [31:0] x, input logic [31:0] y);
    check_x = x;
    check_y = y;
  endtask

  task automatic expect_px(input logic [1:0] ch, input logic [23:0] c);
    sb.push_back({ch, c});
  endtask

  // Output monitor: every accepted output must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      $display("txn out ch=%0d colour=%06h pending=%0d", out_ch, out_colour, sb.size());
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL out_unexpected observed=%0h expected=none", {out_ch, out_colour});
      end
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert ({out_ch, out_colour} === mon_exp) else begin
          errors++;
          $error("FAIL out_pixel observed=%0h expected=%0h", {out_ch, out_colour}, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with pushes presented: they must be ignored.
    reset     = 1'b1;
    in_valid  = 2'b11;
    in_x      = '0;
    in_y      = '0;
    in_colour = '0;
    out_ready = 1'b1;
    set_check(100, 0);
    drive_px(0, 100, 0, 24'h111111);
    drive_px(1, 100, 0, 24'h222222);
    tick(2);
    chk("rst_colour", out_colour, 24'h0);
    chk("rst_ch", out_ch, 2'd0);
    reset    = 1'b0;
    in_valid = 2'b00;
    tick();
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_empty", empty, 1'b1);
    chk("idle_ready", in_ready, 2'b11);
    chk("idle_full", full, 2'b00);

    // Single push, immediate match, one-cycle latency.
    drive_px(0, 0, 0, 24'hAA0000);
    in_valid = 2'b01;
    set_check(0, 0);
    expect_px(2'd0, 24'hAA0000);
    tick();
    in_valid = 2'b00;
    chk("t2_empty_after_push", empty, 1'b0);
    chk("t2_latency", out_valid, 1'b0);
    tick();
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_colour", out_colour, 24'hAA0000);
    chk("t2_ch", out_ch, 2'd0);
    chk("t2_empty", empty, 1'b1);
    set_check(100, 0);
    tick();
    chk("t2_clear", out_valid, 1'b0);

    // Raster order independent of push order.
    drive_px(1, 1, 0, 24'h00BB00);
    in_valid = 2'b10;
    tick();
    drive_px(0, 0, 0, 24'h0000CC);
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    chk("t3_nomatch", out_valid, 1'b0);
    expect_px(2'd0, 24'h0000CC);
    expect_px(2'd1, 24'h00BB00);
    set_check(0, 0);
    tick();
    chk("t3_first_ch", out_ch, 2'd0);
    set_check(1, 0);
    tick();
    chk("t3_second_ch", out_ch, 2'd1);
    chk("t3_second_col", out_colour, 24'h00BB00);
    set_check(100, 0);
    tick();
    chk("t3_empty", empty, 1'b1);
    chk("t3_clear", out_valid, 1'b0);

    // Fill ch0, attempt a fifth push, then drain.
    for (int i = 0; i < 4; i++) begin
      drive_px(0, 10 + i, 0, 24'h400000 + 24'(i));
      in_valid = 2'b01;
      tick();
    end
    drive_px(0, 14, 0, 24'h400004);
    chk("t4_full", full[0], 1'b1);
    chk("t4_ready_low", in_ready[0], 1'b0);
    chk("t4_ch1_ready", in_ready[1], 1'b1);
    tick();
    in_valid = 2'b00;
    chk("t4_still_full", full[0], 1'b1);
    expect_px(2'd0, 24'h400000);
    set_check(10, 0);
    tick();
    chk("t4_ready_after_pop", in_ready[0], 1'b1);
    chk("t4_not_full", full[0], 1'b0);
    for (int i = 1; i < 4; i++) begin
      expect_px(2'd0, 24'h400000 + 24'(i));
      set_check(10 + i, 0);
      tick();
    end
    set_check(100, 0);
    tick();
    chk("t4_drained_empty", empty, 1'b1);

    // Back-pressure holds the output while a second match waits.
    out_ready = 1'b0;
    drive_px(0, 20, 0, 24'h5A5A5A);
    drive_px(1, 21, 0, 24'h5B5B5B);
    in_valid = 2'b11;
    set_check(20, 0);
    tick();
    in_valid = 2'b00;
    tick();
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_colour", out_colour, 24'h5A5A5A);
    set_check(21, 0);
    tick(2);
    chk("t5_hold_colour", out_colour, 24'h5A5A5A);
    chk("t5_hold_ch", out_ch, 2'd0);
    chk("t5_no_pop", empty, 1'b0);
    expect_px(2'd0, 24'h5A5A5A);
    expect_px(2'd1, 24'h5B5B5B);
    out_ready = 1'b1;
    tick();
    chk("t5_next_colour", out_colour, 24'h5B5B5B);
    chk("t5_next_ch", out_ch, 2'd1);
    chk("t5_empty", empty, 1'b1);
    set_check(100, 0);
    tick();
    chk("t5_clear", out_valid, 1'b0);

    // Repeated x on one channel.
    drive_px(0, 5, 0, 24'h600001);
    in_valid = 2'b01;
    tick();
    drive_px(0, 5, 0, 24'h600002);
    tick();
    in_valid = 2'b00;
    expect_px(2'd0, 24'h600001);
`ifndef DEDUP_EN
    expect_px(2'd0, 24'h600002);
`endif
    set_check(5, 0);
    tick(3);
    set_check(100, 0);
    tick();
    chk("t6_empty", empty, 1'b1);
    chk("t6_clear", out_valid, 1'b0);

    // Reset in the middle of traffic.
    out_ready = 1'b0;
    drive_px(1, 30, 0, 24'h700000);
    drive_px(0, 40, 0, 24'h710000);
    in_valid = 2'b11;
    set_check(30, 0);
    tick();
    in_valid = 2'b00;
    tick();
    chk("t7_pre_valid", out_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk("t7_rst_valid", out_valid, 1'b0);
    chk("t7_rst_empty", empty, 1'b1);
    chk("t7_rst_colour", out_colour, 24'h0);
    chk("t7_rst_ready", in_ready, 2'b11);
    reset     = 1'b0;
    out_ready = 1'b1;
    set_check(40, 0);
    tick(2);
    chk("t7_discarded", out_valid, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
